// File: rtl/traffic_light_intersection.sv
// Four-phase Moore controller for a NS/EW intersection; lamps decode the state register, so they change one edge after the phase count expires.
// Free-running leaf block with no handshake or backpressure; only reset alters the sequence.
module traffic_light_intersection #(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green
);

  localparam logic [1:0] NS_GREEN  = 2'd0;
  localparam logic [1:0] NS_YELLOW = 2'd1;
  localparam logic [1:0] EW_GREEN  = 2'd2;
  localparam logic [1:0] EW_YELLOW = 2'd3;

  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_CYCLES - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_last;
  logic       phase_done;

  always_comb begin
    cnt_last  = YELLOW_LAST;
    state_nxt = NS_GREEN;
    case (state)
      NS_GREEN:  begin cnt_last = GREEN_LAST;  state_nxt = NS_YELLOW; end
      NS_YELLOW: begin cnt_last = YELLOW_LAST; state_nxt = EW_GREEN;  end
      EW_GREEN:  begin cnt_last = GREEN_LAST;  state_nxt = EW_YELLOW; end
      EW_YELLOW: begin cnt_last = YELLOW_LAST; state_nxt = NS_GREEN;  end
      default:   begin cnt_last = 8'd0;        state_nxt = NS_GREEN;  end
    endcase
    phase_done = (cnt == cnt_last);
  end

  // Counter runs 0..DUR-1 and never exceeds 254, so 8 bits cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NS_GREEN;
      cnt   <= 8'd0;
    end else if (phase_done) begin
      state <= state_nxt;
      cnt   <= 8'd0;
    end else begin
      cnt   <= cnt + 8'd1;
    end
  end

  // Fail-safe default: any unexpected encoding shows red both ways.
  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    case (state)
      NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_intersection.sv
// Directed bench for traffic_light_intersection: default timing, 1/1 and 255/255 overrides.
module tb_traffic_light_intersection;

  // Lamp vector layout: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  localparam logic [5:0] L_NSG = 6'b001_100;
  localparam logic [5:0] L_NSY = 6'b010_100;
  localparam logic [5:0] L_EWG = 6'b100_001;
  localparam logic [5:0] L_EWY = 6'b100_010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r0 = 1'b1, r1 = 1'b1, r2 = 1'b1;
  logic [5:0] l0, l1, l2;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_intersection u_def (
    .clk(clk), .reset(r0),
    .ns_red(l0[5]), .ns_yellow(l0[4]), .ns_green(l0[3]),
    .ew_red(l0[2]), .ew_yellow(l0[1]), .ew_green(l0[0])
  );

  traffic_light_intersection #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1)) u_min (
    .clk(clk), .reset(r1),
    .ns_red(l1[5]), .ns_yellow(l1[4]), .ns_green(l1[3]),
    .ew_red(l1[2]), .ew_yellow(l1[1]), .ew_green(l1[0])
  );

  traffic_light_intersection #(.GREEN_CYCLES(255), .YELLOW_CYCLES(255)) u_max (
    .clk(clk), .reset(r2),
    .ns_red(l2[5]), .ns_yellow(l2[4]), .ns_green(l2[3]),
    .ew_red(l2[2]), .ew_yellow(l2[1]), .ew_green(l2[0])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected lamps t edges after the last reset edge (t=0 is that edge).
  function automatic logic [5:0] exp_lamp(input int t, input int g, input int y);
    int p;
    p = t % (2 * (g + y));
    if (p < g)           return L_NSG;
    else if (p < g + y)  return L_NSY;
    else if (p < 2*g + y) return L_EWG;
    else                 return L_EWY;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_inv(input logic [5:0] l);
    check("inv_ns_onehot", 32'($onehot(l[5:3])), 32'd1);
    check("inv_ew_onehot", 32'($onehot(l[2:0])), 32'd1);
    check("inv_one_red",   32'(l[5] | l[2]), 32'd1);
    check("inv_no_2green", 32'(l[3] & l[0]), 32'd0);
    check("inv_yel_vs_grn", 32'((l[4] & l[0]) | (l[1] & l[3])), 32'd0);
  endtask

  initial begin
    // Reset held for 10 edges: NS green throughout.
    r0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_hold", 32'(l0), 32'(L_NSG));
    end
    r0 = 1'b0;
    // Counting starts on the first edge with reset low; 200 cycles with invariants.
    for (int t = 1; t <= 200; t++) begin
      tick();
      check("seq_def", 32'(l0), 32'(exp_lamp(t, 8, 3)));
      check_inv(l0);
    end

    // Fresh reset, run into EW green, reset at cycle 14.
    r0 = 1'b1;
    tick();
    check("rst_again", 32'(l0), 32'(L_NSG));
    r0 = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      check("pre_mid_rst", 32'(l0), 32'(exp_lamp(t, 8, 3)));
    end
    check("in_ew_green", 32'(l0), 32'(L_EWG));
    r0 = 1'b1;
    tick();
    check("mid_rst", 32'(l0), 32'(L_NSG));
    r0 = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      check("post_mid_rst", 32'(l0), 32'(exp_lamp(t, 8, 3)));
      check_inv(l0);
    end

    // GREEN=YELLOW=1: phase changes every edge, period 4.
    r1 = 1'b1;
    tick();
    check("min_rst", 32'(l1), 32'(L_NSG));
    r1 = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check("seq_min", 32'(l1), 32'(exp_lamp(t, 1, 1)));
      check_inv(l1);
    end

    // GREEN=YELLOW=255: each phase 255 cycles, period 1020, run past two periods.
    r2 = 1'b1;
    tick();
    check("max_rst", 32'(l2), 32'(L_NSG));
    r2 = 1'b0;
    for (int t = 1; t <= 2100; t++) begin
      tick();
      check("seq_max", 32'(l2), 32'(exp_lamp(t, 255, 255)));
      if (t == 254)  check("max_g_last",  32'(l2), 32'(L_NSG));
      if (t == 255)  check("max_y_first", 32'(l2), 32'(L_NSY));
      if (t == 1019) check("max_wrap_pre", 32'(l2), 32'(L_EWY));
      if (t == 1020) check("max_wrap",    32'(l2), 32'(L_NSG));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
